// File: rtl/panda_mem_stage.sv
// Panda MEM stage: load/store sequencing over a req/gnt/rvalid data bus, byte-lane steering, MEM/WB register.
// Optional feature macro: PANDA_MEM_MISALIGN_CHECK_EN (drop misaligned half/word accesses, pulse misalign_o).
module panda_mem_stage #(
  parameter int AddrWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_load_i,
  input  logic                 ex_store_i,
  input  logic [1:0]           ex_width_i,
  input  logic                 ex_unsigned_i,
  input  logic [AddrWidth-1:0] ex_addr_i,
  input  logic [31:0]          ex_wdata_i,
  input  logic [4:0]           ex_rd_addr_i,
  input  logic                 ex_rd_we_i,
  input  logic [31:0]          ex_rd_data_i,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [AddrWidth-1:0] data_addr_o,
  output logic [31:0]          data_wdata_o,
  input  logic [31:0]          data_rdata_i,
  output logic                 stall_o,
  output logic                 misalign_o,
  output logic [4:0]           wb_rd_addr_o,
  output logic                 wb_rd_we_o,
  output logic [31:0]          wb_rd_data_o
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RVALID} state_e;

  state_e      state, state_nxt;
  logic        mem_op, misaligned, issue;
  logic [3:0]  be;
  logic [31:0] wdata_st;
  logic [1:0]  off_q, width_q;
  logic        uns_q;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_data;

  assign mem_op = ex_valid_i & (ex_load_i | ex_store_i);

`ifdef PANDA_MEM_MISALIGN_CHECK_EN
  logic misalign_q;
  assign misaligned = ((ex_width_i == 2'b01) & ex_addr_i[0]) |
                      (ex_width_i[1] & (ex_addr_i[1:0] != 2'b00));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= (state == IDLE) & mem_op & misaligned;
  end
  assign misalign_o = misalign_q;
`else
  assign misaligned = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign issue = mem_op & ~misaligned;

  // Lane steering; half uses addr[1] only and word always lane 0, so low bits beyond that are ignored.
  always_comb begin
    be       = 4'b1111;
    wdata_st = ex_wdata_i;
    case (ex_width_i)
      2'b00: begin
        be       = 4'b0001 << ex_addr_i[1:0];
        wdata_st = {4{ex_wdata_i[7:0]}};
      end
      2'b01: begin
        be       = 4'b0011 << {ex_addr_i[1], 1'b0};
        wdata_st = {2{ex_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    data_req_o = 1'b0;
    stall_o    = 1'b0;
    case (state)
      IDLE: if (issue) begin
        data_req_o = 1'b1;
        stall_o    = 1'b1;
        state_nxt  = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
      end
      WAIT_GNT: begin
        data_req_o = 1'b1;
        stall_o    = 1'b1;
        if (data_gnt_i) state_nxt = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        stall_o = ~data_rvalid_i;
        if (data_rvalid_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign data_we_o    = data_req_o & ex_store_i;
  assign data_be_o    = data_req_o ? be : 4'b0000;
  assign data_addr_o  = data_req_o ? {ex_addr_i[AddrWidth-1:2], 2'b00} : '0;
  assign data_wdata_o = data_req_o ? wdata_st : 32'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Extraction context captured when the request is accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      off_q   <= 2'b00;
      width_q <= 2'b00;
      uns_q   <= 1'b0;
    end else if (data_req_o && data_gnt_i) begin
      off_q   <= ex_addr_i[1:0];
      width_q <= ex_width_i;
      uns_q   <= ex_unsigned_i;
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_v = data_rdata_i[7:0];
      2'd1:    byte_v = data_rdata_i[15:8];
      2'd2:    byte_v = data_rdata_i[23:16];
      default: byte_v = data_rdata_i[31:24];
    endcase
    half_v = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (width_q)
      2'b00:   ld_data = uns_q ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   ld_data = uns_q ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: ld_data = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_rd_addr_o <= 5'd0;
      wb_rd_we_o   <= 1'b0;
      wb_rd_data_o <= 32'h0;
    end else if (state == WAIT_RVALID && data_rvalid_i) begin
      wb_rd_addr_o <= ex_rd_addr_i;
      wb_rd_we_o   <= ex_load_i & ex_rd_we_i;
      wb_rd_data_o <= ex_load_i ? ld_data : ex_rd_data_i;
    end else if (stall_o || !ex_valid_i || mem_op) begin
      // stalled, bubble, or dropped misaligned access
      wb_rd_we_o <= 1'b0;
    end else begin
      wb_rd_addr_o <= ex_rd_addr_i;
      wb_rd_we_o   <= ex_rd_we_i;
      wb_rd_data_o <= ex_rd_data_i;
    end
  end

endmodule

// File: tb/tb_panda_mem_stage.sv
// Directed bench for panda_mem_stage: table of single-wait accesses plus hand-written corner sequences.
module tb_panda_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store, ex_unsigned, ex_rd_we;
  logic [1:0]  ex_width;
  logic [31:0] ex_addr, ex_wdata, ex_rd_data;
  logic [4:0]  ex_rd_addr;
  logic        data_req, data_gnt, data_rvalid, data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        stall, misalign;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_we;
  logic [31:0] wb_rd_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  panda_mem_stage #(.AddrWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_load_i(ex_load), .ex_store_i(ex_store),
    .ex_width_i(ex_width), .ex_unsigned_i(ex_unsigned), .ex_addr_i(ex_addr),
    .ex_wdata_i(ex_wdata), .ex_rd_addr_i(ex_rd_addr), .ex_rd_we_i(ex_rd_we),
    .ex_rd_data_i(ex_rd_data),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
    .data_wdata_o(data_wdata), .data_rdata_i(data_rdata),
    .stall_o(stall), .misalign_o(misalign),
    .wb_rd_addr_o(wb_rd_addr), .wb_rd_we_o(wb_rd_we), .wb_rd_data_o(wb_rd_data)
  );

  typedef struct {
    logic        ld, st, uns, rd_we;
    logic [1:0]  w;
    logic [31:0] addr, wdata, rdata;
    logic [4:0]  rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_wb;
    logic        exp_we;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_load = 0; ex_store = 0; ex_width = 0; ex_unsigned = 0;
    ex_addr = 0; ex_wdata = 0; ex_rd_addr = 0; ex_rd_we = 0; ex_rd_data = 0;
    data_gnt = 0; data_rvalid = 0; data_rdata = 0;
  endtask

  task automatic set_mem(input logic ld, input logic st, input logic [1:0] w, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic rdwe);
    ex_valid = 1; ex_load = ld; ex_store = st; ex_width = w; ex_unsigned = uns;
    ex_addr = addr; ex_wdata = wd; ex_rd_addr = rd; ex_rd_we = rdwe; ex_rd_data = 32'h5555_5555;
  endtask

  initial begin
    vecs[0] = '{ld:1, st:0, uns:0, rd_we:1, w:2'b00, addr:32'h103, wdata:0, rdata:32'h80FF_0000, rd:3,
                exp_be:4'b1000, exp_wd:0, exp_wb:32'hFFFF_FF80, exp_we:1};
    vecs[1] = '{ld:1, st:0, uns:1, rd_we:1, w:2'b00, addr:32'h101, wdata:0, rdata:32'h0000_9A00, rd:4,
                exp_be:4'b0010, exp_wd:0, exp_wb:32'h0000_009A, exp_we:1};
    vecs[2] = '{ld:1, st:0, uns:0, rd_we:1, w:2'b01, addr:32'h002, wdata:0, rdata:32'h8001_1234, rd:6,
                exp_be:4'b1100, exp_wd:0, exp_wb:32'hFFFF_8001, exp_we:1};
    vecs[3] = '{ld:1, st:0, uns:0, rd_we:1, w:2'b01, addr:32'h000, wdata:0, rdata:32'h8001_7FFE, rd:7,
                exp_be:4'b0011, exp_wd:0, exp_wb:32'h0000_7FFE, exp_we:1};
    vecs[4] = '{ld:1, st:0, uns:1, rd_we:1, w:2'b10, addr:32'h010, wdata:0, rdata:32'hDEAD_BEEF, rd:8,
                exp_be:4'b1111, exp_wd:0, exp_wb:32'hDEAD_BEEF, exp_we:1};
    vecs[5] = '{ld:0, st:1, uns:0, rd_we:0, w:2'b00, addr:32'h201, wdata:32'h0000_00AB, rdata:0, rd:0,
                exp_be:4'b0010, exp_wd:32'hABAB_ABAB, exp_wb:32'h0, exp_we:0};
    vecs[6] = '{ld:0, st:1, uns:0, rd_we:0, w:2'b01, addr:32'h202, wdata:32'h1234_5678, rdata:0, rd:0,
                exp_be:4'b1100, exp_wd:32'h5678_5678, exp_wb:32'h0, exp_we:0};
    vecs[7] = '{ld:0, st:1, uns:0, rd_we:0, w:2'b10, addr:32'h300, wdata:32'hCAFE_F00D, rdata:0, rd:0,
                exp_be:4'b1111, exp_wd:32'hCAFE_F00D, exp_wb:32'h0, exp_we:0};
    vecs[8] = '{ld:1, st:0, uns:0, rd_we:0, w:2'b00, addr:32'h100, wdata:0, rdata:32'h0000_007F, rd:9,
                exp_be:4'b0001, exp_wd:0, exp_wb:32'h0000_007F, exp_we:0};

    clear_ex();
    rst = 1;
    #12;
    chk("rst req", data_req, 0);      chk("rst be", data_be, 0);
    chk("rst addr", data_addr, 0);    chk("rst stall", stall, 0);
    chk("rst misalign", misalign, 0); chk("rst wb_we", wb_rd_we, 0);
    chk("rst wb_data", wb_rd_data, 0); chk("rst wb_addr", wb_rd_addr, 0);
    @(negedge clk); rst = 0;

    // ALU pass-through
    ex_valid = 1; ex_rd_addr = 5; ex_rd_we = 1; ex_rd_data = 32'h1234;
    #1 chk("alu stall", stall, 0); chk("alu req", data_req, 0);
    @(posedge clk); #1;
    chk("alu wb_addr", wb_rd_addr, 5); chk("alu wb_we", wb_rd_we, 1);
    chk("alu wb_data", wb_rd_data, 32'h1234); chk("alu stall2", stall, 0);
    @(negedge clk); ex_valid = 0;
    @(posedge clk); #1 chk("bubble wb_we", wb_rd_we, 0);

    // Table: gnt in the request cycle, rvalid the next; entries run back to back.
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      set_mem(vecs[i].ld, vecs[i].st, vecs[i].w, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              vecs[i].rd, vecs[i].rd_we);
      data_gnt = 1; data_rvalid = 0;
      #1;
      chk($sformatf("v%0d req", i), data_req, 1);
      chk($sformatf("v%0d stall", i), stall, 1);
      chk($sformatf("v%0d we", i), data_we, vecs[i].st);
      chk($sformatf("v%0d be", i), data_be, vecs[i].exp_be);
      chk($sformatf("v%0d addr", i), data_addr, {vecs[i].addr[31:2], 2'b00});
      if (vecs[i].st) chk($sformatf("v%0d wdata", i), data_wdata, vecs[i].exp_wd);
      @(posedge clk); #1;
      chk($sformatf("v%0d wait wb_we", i), wb_rd_we, 0);
      chk($sformatf("v%0d wait stall", i), stall, 1);
      @(negedge clk);
      data_gnt = 0; data_rvalid = 1; data_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d rv req", i), data_req, 0);
      chk($sformatf("v%0d rv stall", i), stall, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d wb_we", i), wb_rd_we, vecs[i].exp_we);
      if (vecs[i].ld) begin
        chk($sformatf("v%0d wb_data", i), wb_rd_data, vecs[i].exp_wb);
        chk($sformatf("v%0d wb_addr", i), wb_rd_addr, vecs[i].rd);
      end
      @(negedge clk);
      data_rvalid = 0;
    end

    // rvalid while idle is ignored
    clear_ex(); data_rvalid = 1;
    #1 chk("idle rv stall", stall, 0);
    @(posedge clk); #1 chk("idle rv wb_we", wb_rd_we, 0);
    @(negedge clk); data_rvalid = 0;

    // LHU with gnt delayed 3 cycles, stray rvalid during WAIT_GNT
    set_mem(1, 0, 2'b01, 1, 32'h102, 0, 10, 1);
    for (int c = 0; c < 3; c++) begin
      data_rvalid = (c == 1);
      #1;
      chk($sformatf("lhu w%0d req", c), data_req, 1);
      chk($sformatf("lhu w%0d addr", c), data_addr, 32'h100);
      chk($sformatf("lhu w%0d be", c), data_be, 4'b1100);
      chk($sformatf("lhu w%0d stall", c), stall, 1);
      @(posedge clk); #1 chk($sformatf("lhu w%0d wb_we", c), wb_rd_we, 0);
      @(negedge clk);
    end
    data_rvalid = 0; data_gnt = 1;
    #1 chk("lhu gnt req", data_req, 1); chk("lhu gnt be", data_be, 4'b1100);
    @(negedge clk); data_gnt = 0; data_rvalid = 1; data_rdata = 32'hBEEF_0000;
    #1 chk("lhu rv stall", stall, 0);
    @(posedge clk); #1;
    chk("lhu wb_we", wb_rd_we, 1); chk("lhu wb_data", wb_rd_data, 32'h0000_BEEF);
    chk("lhu wb_addr", wb_rd_addr, 10);
    @(negedge clk); clear_ex();

    // Reset in WAIT_RVALID, rvalid arriving after release
    set_mem(1, 0, 2'b10, 0, 32'h40, 0, 11, 1); data_gnt = 1;
    @(posedge clk); #1 chk("rstm stall", stall, 1);
    @(negedge clk); data_gnt = 0; rst = 1; ex_valid = 0;
    #1 chk("rstm req", data_req, 0); chk("rstm stall0", stall, 0);
    @(negedge clk); rst = 0; data_rvalid = 1; data_rdata = 32'h1111_2222;
    #1 chk("rstm late stall", stall, 0); chk("rstm late req", data_req, 0);
    @(posedge clk); #1 chk("rstm wb_we", wb_rd_we, 0); chk("rstm wb_data", wb_rd_data, 0);
    @(negedge clk); clear_ex();

    // LW at 0x102: dropped when checking, otherwise aligned down
    set_mem(1, 0, 2'b10, 0, 32'h102, 0, 12, 1);
`ifdef PANDA_MEM_MISALIGN_CHECK_EN
    #1 chk("mis req", data_req, 0); chk("mis stall", stall, 0);
    chk("mis pre", misalign, 0);
    @(posedge clk); #1 chk("mis pulse", misalign, 1); chk("mis wb_we", wb_rd_we, 0);
    @(negedge clk); clear_ex();
    @(posedge clk); #1 chk("mis end", misalign, 0);
`else
    data_gnt = 1;
    #1 chk("lw102 req", data_req, 1); chk("lw102 addr", data_addr, 32'h100);
    chk("lw102 be", data_be, 4'b1111); chk("lw102 misalign", misalign, 0);
    @(negedge clk); data_gnt = 0; data_rvalid = 1; data_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1 chk("lw102 wb_data", wb_rd_data, 32'h0BAD_F00D);
    chk("lw102 wb_we", wb_rd_we, 1);
    @(negedge clk); clear_ex();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
